simon_button_arbiter: RTL and testbench

Front-end controller between the four raw push-buttons and the Simon game FSM. It debounces each button, waits until the game arms it, and reports exactly one press: the first debounced rising edge, lowest index on ties. The press is delivered through a valid/ready handshake. If no press arrives within a programmable window, it raises a one-cycle timeout. The debounced levels are also exported for LED feedback.

---
 rtl/simon_input_pkg.sv | 14 +
 rtl/btn_debounce_ch.sv | 44 ++++
 rtl/simon_button_arbiter.sv | 106 ++++++++++
 tb/tb_simon_button_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_input_pkg.sv
// Shared types and constants for the Simon button front-end.
package simon_input_pkg;

  localparam int N_BTN     = 4;
  localparam int BTN_IDX_W = $clog2(N_BTN);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_WAIT_RELEASE = 2'd1,
    S_ARMED        = 2'd2,
    S_REPORT       = 2'd3
  } state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: the output follows the input only after DB_CYCLES
// consecutive cycles of disagreement.
module btn_debounce_ch #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = '0;
    out_d = out_q;
    if (in != out_q) begin
      if (cnt_q == CNT_LAST) begin
        out_d = in;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/simon_button_arbiter.sv
// Debounces the four game buttons and reports one armed press (first rising
// edge, lowest index on ties) over valid/ready, with an arm-window timeout.
module simon_button_arbiter #(
  parameter int N_BTN          = 4,
  parameter int DB_CYCLES      = 1_000_000,
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_BTN-1:0]         btn_raw,
  input  logic                     arm,
  input  logic                     abort,
  output logic                     press_valid,
  output logic [$clog2(N_BTN)-1:0] press_idx,
  input  logic                     press_ready,
  output logic                     timeout,
  output logic                     armed,
  output logic [N_BTN-1:0]         btn_db
);

  import simon_input_pkg::*;

  localparam int IDX_W = $clog2(N_BTN);
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, first_idx;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timeout_q, timeout_d;
  logic [N_BTN-1:0] btn_db_q, rise;

  for (genvar i = 0; i < N_BTN; i++) begin : g_db
    btn_debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_ch (
      .clock (clock),
      .reset (reset),
      .in    (btn_raw[i]),
      .out   (btn_db[i])
    );
  end

  assign rise = btn_db & ~btn_db_q;

  // Descending scan so the lowest set index is the one left standing.
  always_comb begin
    first_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (rise[i]) first_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timeout_d = 1'b0;
    // Any non-ARMED cycle zeroes the timer, so it reads 0 on ARMED entry.
    timer_d   = (state_q == S_ARMED) ? timer_q + TMR_W'(1) : '0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) state_d = (|btn_db) ? S_WAIT_RELEASE : S_ARMED;
        end
        S_WAIT_RELEASE: begin
          if (btn_db == '0) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (|rise) begin
            state_d = S_REPORT;
            idx_d   = first_idx;
          end else if (timer_q == TMR_LAST) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
          end
        end
        S_REPORT: begin
          if (press_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      btn_db_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      btn_db_q  <= btn_db;
    end
  end

  assign press_valid = (state_q == S_REPORT);
  assign press_idx   = idx_q;
  assign timeout     = timeout_q;
  assign armed       = (state_q == S_WAIT_RELEASE) || (state_q == S_ARMED);

endmodule

// File: tb/tb_simon_button_arbiter.sv
// Bench for simon_button_arbiter: vector table, hand-written corner cases and
// a randomized run against a window-based reference model.
`timescale 1ns/1ps
module tb_simon_button_arbiter;

  localparam int NB = 4;
  localparam int DB = 4;
  localparam int TO = 20;

  localparam int M_IDLE   = 0;
  localparam int M_WAIT   = 1;
  localparam int M_ARMED  = 2;
  localparam int M_REPORT = 3;

  logic       clock = 1'b0;
  logic       reset, arm, abort, press_ready;
  logic       press_valid, timeout, armed;
  logic [3:0] btn_raw, btn_db;
  logic [1:0] press_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  simon_button_arbiter #(
    .N_BTN(NB), .DB_CYCLES(DB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .arm         (arm),
    .abort       (abort),
    .press_valid (press_valid),
    .press_idx   (press_idx),
    .press_ready (press_ready),
    .timeout     (timeout),
    .armed       (armed),
    .btn_db      (btn_db)
  );

  typedef struct {
    logic [3:0] raw;
    logic       arm;
    logic       rdy;
    logic [3:0] db;
    logic       valid;
    logic [1:0] idx;
    logic       armed;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: debounced levels come from a window of the last
  // DB raw samples; the timeout is measured in edges since ARMED entry.
  logic [3:0] hist[$];
  logic [3:0] m_db, m_db_q;
  int         m_mode, m_idx, m_n, m_entry;
  logic       m_to;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic a, input logic ab, input logic rd);
    btn_raw     = r;
    arm         = a;
    abort       = ab;
    press_ready = rd;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic [3:0] r, input logic a, input logic rd,
                     input logic [3:0] d, input logic v, input logic [1:0] i, input logic am);
    vecs.push_back('{r, a, rd, d, v, i, am});
  endtask

  task automatic wait_valid(input int max_cycles, input string name);
    int k = 0;
    while (!press_valid && k < max_cycles) begin
      step();
      k++;
    end
    check({name, " wait valid"}, press_valid, 1);
  endtask

  task automatic model_edge(input logic [3:0] r, input logic a, input logic ab,
                            input logic rd, input logic rs);
    logic [3:0] rise_m, nd;
    logic       all_diff;
    if (rs) begin
      m_db = '0; m_db_q = '0; hist.delete();
      m_mode = M_IDLE; m_idx = 0; m_to = 1'b0; m_n = 0; m_entry = 0;
      return;
    end
    m_n++;
    rise_m = m_db & ~m_db_q;
    hist.push_back(r);
    if (hist.size() > DB) void'(hist.pop_front());
    nd = m_db;
    for (int i = 0; i < NB; i++) begin
      all_diff = (hist.size() == DB);
      foreach (hist[j]) if (hist[j][i] == m_db[i]) all_diff = 1'b0;
      if (all_diff) nd[i] = ~m_db[i];
    end
    m_to = 1'b0;
    if (ab) begin
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE: if (a) begin
          if (m_db != 0) m_mode = M_WAIT;
          else begin m_mode = M_ARMED; m_entry = m_n; end
        end
        M_WAIT: if (m_db == 0) begin m_mode = M_ARMED; m_entry = m_n; end
        M_ARMED: begin
          if (rise_m != 0) begin
            for (int i = 0; i < NB; i++) if (rise_m[i]) begin m_idx = i; break; end
            m_mode = M_REPORT;
          end else if (m_n - m_entry == TO) begin
            m_to = 1'b1;
            m_mode = M_IDLE;
          end
        end
        default: if (rd) m_mode = M_IDLE;
      endcase
    end
    m_db_q = m_db;
    m_db   = nd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       seen;
    logic [3:0] r;
    logic       a, ab, rd, rs;
    int         hold;

    reset = 1'b1;
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check("reset outputs", {btn_db, press_valid, press_idx, timeout, armed}, 0);
    reset = 1'b0;

    // Glitches, a long pulse, then a single accepted press of button 2.
    repeat (3) add(4'b0100, 0, 0, 4'h0,    0, 0, 0);
    repeat (2) add(4'b0000, 0, 0, 4'h0,    0, 0, 0);
    repeat (3) add(4'b0100, 0, 0, 4'h0,    0, 0, 0);
    repeat (3) add(4'b0100, 0, 0, 4'b0100, 0, 0, 0);
    repeat (3) add(4'b0000, 0, 0, 4'b0100, 0, 0, 0);
    repeat (2) add(4'b0000, 0, 0, 4'h0,    0, 0, 0);
    add(4'b0000, 1, 0, 4'h0, 0, 0, 1);
    repeat (3) add(4'b0100, 0, 1, 4'h0, 0, 0, 1);
    add(4'b0100, 0, 1, 4'b0100, 0, 0, 1);
    add(4'b0100, 0, 1, 4'b0100, 1, 2, 0);
    add(4'b0100, 0, 1, 4'b0100, 0, 2, 0);
    repeat (3) add(4'b0000, 0, 0, 4'b0100, 0, 2, 0);
    add(4'b0000, 0, 0, 4'h0, 0, 2, 0);

    foreach (vecs[j]) begin
      drive(vecs[j].raw, vecs[j].arm, 1'b0, vecs[j].rdy);
      step();
      check($sformatf("vec%0d", j), {btn_db, press_valid, press_idx, armed, timeout},
            {vecs[j].db, vecs[j].valid, vecs[j].idx, vecs[j].armed, 1'b0});
    end

    // Tie on buttons 1 and 3 with backpressure.
    drive(4'h0, 1'b1, 1'b0, 1'b0); step();
    check("tie armed", armed, 1);
    drive(4'b1010, 1'b0, 1'b0, 1'b0);
    repeat (4) step();
    check("tie db", btn_db, 4'b1010);
    step();
    check("tie first", {press_valid, press_idx}, 3'b101);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("tie hold%0d", k), {press_valid, press_idx}, 3'b101);
    end
    drive(4'b1010, 1'b0, 1'b0, 1'b1); step();
    check("tie accept", {press_valid, armed}, 2'b00);
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    repeat (6) step();

    // Held button must be released before a new press counts.
    drive(4'b0001, 1'b0, 1'b0, 1'b0);
    repeat (5) step();
    check("held db", btn_db, 4'b0001);
    drive(4'b0001, 1'b1, 1'b0, 1'b0); step();
    check("held armed", armed, 1);
    drive(4'b0001, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    repeat (10) begin step(); seen |= press_valid; end
    check("held no report", {seen, armed}, 2'b01);
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    repeat (5) step();
    check("held released", {btn_db, armed, press_valid}, 6'b000010);
    drive(4'b1000, 1'b0, 1'b0, 1'b0);
    wait_valid(20, "held");
    check("held idx", press_idx, 3);
    drive(4'b1000, 1'b0, 1'b0, 1'b1); step();
    check("held accept", press_valid, 0);
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    repeat (6) step();

    // Timeout with no press.
    drive(4'h0, 1'b1, 1'b0, 1'b0); step();
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < TO; k++) begin
      step();
      check($sformatf("to quiet%0d", k), {timeout, armed}, 2'b01);
    end
    step();
    check("to pulse", {timeout, armed}, 2'b10);
    step();
    check("to one cycle", {timeout, armed}, 2'b00);

    // A rise in the last timer cycle wins over the timeout.
    drive(4'h0, 1'b1, 1'b0, 1'b0); step();
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    repeat (15) step();
    drive(4'b0001, 1'b0, 1'b0, 1'b0);
    repeat (4) step();
    check("late db", {btn_db, armed, press_valid, timeout}, 7'b0001100);
    step();
    check("late report", {press_valid, press_idx, timeout, armed}, 5'b10000);
    drive(4'b0001, 1'b0, 1'b0, 1'b1); step();
    check("late accept", {press_valid, timeout}, 2'b00);
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    repeat (6) begin step(); seen |= timeout; end
    check("late no timeout", seen, 0);

    // Abort in ARMED.
    drive(4'h0, 1'b1, 1'b0, 1'b0); step();
    drive(4'h0, 1'b0, 1'b1, 1'b0); step();
    check("abort armed", armed, 0);
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    repeat (25) begin step(); seen |= timeout; end
    check("abort no timeout", seen, 0);

    // Abort in the cycle the timeout would fire.
    drive(4'h0, 1'b1, 1'b0, 1'b0); step();
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    repeat (TO - 1) step();
    drive(4'h0, 1'b0, 1'b1, 1'b0); step();
    check("abort at timeout", {timeout, armed}, 2'b00);
    drive(4'h0, 1'b0, 1'b0, 1'b0); step();
    check("abort at timeout next", timeout, 0);

    // Abort together with ready in REPORT.
    drive(4'h0, 1'b1, 1'b0, 1'b0); step();
    drive(4'b0010, 1'b0, 1'b0, 1'b0);
    wait_valid(10, "abrdy");
    check("abrdy idx", press_idx, 1);
    drive(4'b0010, 1'b0, 1'b1, 1'b1); step();
    check("abrdy done", {press_valid, armed}, 2'b00);
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    repeat (6) step();

    // Reset while a report is pending.
    drive(4'h0, 1'b1, 1'b0, 1'b0); step();
    drive(4'b0100, 1'b0, 1'b0, 1'b0);
    wait_valid(10, "rst");
    reset = 1'b1; step();
    check("rst in report", {btn_db, press_valid, press_idx, timeout, armed}, 0);
    reset = 1'b0;
    drive(4'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) step();

    // Randomized run against the reference model.
    hold = 0;
    r = 4'h0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        r    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        hold = $urandom_range(1, 24);
      end
      hold--;
      a  = ($urandom_range(0, 5) == 0);
      ab = ($urandom_range(0, 59) == 0);
      rd = 1'($urandom_range(0, 1));
      rs = (c == 0) || ($urandom_range(0, 499) == 0);
      drive(r, a, ab, rd);
      reset = rs;
      model_edge(r, a, ab, rd, rs);
      step();
      check($sformatf("rand c%0d", c), {btn_db, press_valid, press_idx, timeout, armed},
            {m_db, m_mode == M_REPORT, 2'(m_idx), m_to, (m_mode == M_WAIT) || (m_mode == M_ARMED)});
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
